vend_ctrl_mux: RTL

//  Parametrised vending-machine core with integrated display scanning. Accepts coins, prices a
//  one-hot product from a parameter table, vends on a buy request, pays change one coin at a time,
//  and multiplexes balance and selected cost onto a NUM_DIGITS seven-segment display.

---
 rtl/vend_ctrl_mux_pkg.sv | 50 +++++
 rtl/vend_ctrl_mux_scan.sv | 66 ++++++
 rtl/vend_ctrl_mux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_mux_pkg.sv
// Shared definitions for the vending controller: coin coding, FSM states, 7-segment decoder.
package vend_ctrl_mux_pkg;

    localparam int unsigned CoinW = 3;

    // Bit positions of the one-hot coin / change_coin encoding
    localparam int unsigned Coin5Idx  = 0;
    localparam int unsigned Coin10Idx = 1;
    localparam int unsigned Coin25Idx = 2;

    localparam logic [CoinW-1:0] Coin5Bit  = CoinW'(1 << Coin5Idx);
    localparam logic [CoinW-1:0] Coin10Bit = CoinW'(1 << Coin10Idx);
    localparam logic [CoinW-1:0] Coin25Bit = CoinW'(1 << Coin25Idx);

    // Coin values in cents
    localparam int unsigned Coin5Val  = 5;
    localparam int unsigned Coin10Val = 10;
    localparam int unsigned Coin25Val = 25;

    typedef enum logic [1:0] {
        StIdle,
        StVend,
        StChange
    } state_e;

    // Hex digit to active-low cathodes, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] hex2sevseg(input logic [3:0] hex);
        logic [6:0] seg;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/vend_ctrl_mux_scan.sv
// Display scanner: steps one digit every REFRESH_DIV cycles; low half shows balance nibbles,
// high half shows cost nibbles.
module vend_ctrl_mux_scan
    import vend_ctrl_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BAL_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BAL_W-1:0]      balance,
    input  logic [BAL_W-1:0]      cost,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            CA
);

    localparam int unsigned RefW    = $clog2(REFRESH_DIV);
    localparam int unsigned DigW    = $clog2(NUM_DIGITS);
    localparam int unsigned HalfDig = NUM_DIGITS / 2;

    logic [RefW-1:0]  refresh_q;
    logic [DigW-1:0]  digit_q;
    logic             on_q;
    logic [BAL_W-1:0] nib_src;
    logic [BAL_W-1:0] shifted;
    logic [DigW-1:0]  nib_idx;

    // Refresh divider and digit index; on_q keeps all anodes dark until the first clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            digit_q   <= '0;
            on_q      <= 1'b0;
        end else begin
            on_q <= 1'b1;
            if (refresh_q == RefW'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                digit_q   <= (digit_q == DigW'(NUM_DIGITS - 1)) ? '0 : digit_q + DigW'(1);
            end else begin
                refresh_q <= refresh_q + RefW'(1);
            end
        end
    end

    // Nibble select; shifting past BAL_W naturally yields zero for absent nibbles.
    always_comb begin
        nib_src = balance;
        nib_idx = digit_q;
        if (digit_q >= DigW'(HalfDig)) begin
            nib_src = cost;
            nib_idx = digit_q - DigW'(HalfDig);
        end
        shifted = nib_src >> {nib_idx, 2'b00};
        CA      = hex2sevseg(shifted[3:0]);
    end

    // One-hot-cold anode drive for the active digit.
    always_comb begin
        AN = '1;
        if (on_q) begin
            AN[digit_q] = 1'b0;
        end
    end

endmodule

// File: rtl/vend_ctrl_mux.sv
// Vending-machine core: coin credit, one-hot product pricing, vend, paced change payout,
// plus multiplexed seven-segment display of balance and selected cost.
module vend_ctrl_mux
    import vend_ctrl_mux_pkg::*;
#(
    parameter int unsigned                     NUM_PRODUCTS = 4,
    parameter int unsigned                     BAL_W        = 8,
    parameter logic [NUM_PRODUCTS*BAL_W-1:0]   PRICES       = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter int unsigned                     MAX_BALANCE  = 255,
    parameter int unsigned                     NUM_DIGITS   = 4,
    parameter int unsigned                     REFRESH_DIV  = 100000,
    parameter int unsigned                     CHANGE_GAP   = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CoinW-1:0]        coin,
    input  logic [NUM_PRODUCTS-1:0] product,
    input  logic                    buy,
    input  logic                    refund,
    output logic [BAL_W-1:0]        balance,
    output logic [NUM_PRODUCTS-1:0] vend,
    output logic [CoinW-1:0]        change_coin,
    output logic                    coin_reject,
    output logic                    err,
    output logic                    busy,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              CA
);

    localparam int unsigned    SumW      = BAL_W + 1;
    localparam int unsigned    GapW      = $clog2(CHANGE_GAP + 1);
    localparam logic [GapW-1:0] GapReload = GapW'(CHANGE_GAP - 1);

    state_e                  state_q;
    logic [BAL_W-1:0]        balance_q;
    logic [BAL_W-1:0]        cost_q;
    logic [GapW-1:0]         gap_q;
    logic [NUM_PRODUCTS-1:0] vend_q;
    logic [CoinW-1:0]        change_coin_q;
    logic                    coin_reject_q;
    logic                    err_q;

    logic                    prod_ok;
    logic [BAL_W-1:0]        prod_cost;
    logic                    coin_ok;
    logic [BAL_W-1:0]        coin_val;
    logic [SumW-1:0]         coin_sum;
    logic                    coin_fits;
    logic [CoinW-1:0]        chg_coin;
    logic [BAL_W-1:0]        chg_val;

    // Price lookup for the live product select; invalid selections cost 0.
    always_comb begin
        prod_ok   = $onehot(product);
        prod_cost = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (product[i]) begin
                prod_cost = prod_cost | PRICES[i*BAL_W +: BAL_W];
            end
        end
        if (!prod_ok) begin
            prod_cost = '0;
        end
    end

    // Coin decode and overflow check, done one bit wider so the sum cannot wrap.
    always_comb begin
        coin_ok  = 1'b1;
        coin_val = '0;
        case (coin)
            Coin5Bit:  coin_val = BAL_W'(Coin5Val);
            Coin10Bit: coin_val = BAL_W'(Coin10Val);
            Coin25Bit: coin_val = BAL_W'(Coin25Val);
            default:   coin_ok  = 1'b0;
        endcase
        coin_sum  = SumW'(balance_q) + SumW'(coin_val);
        coin_fits = (coin_sum <= SumW'(MAX_BALANCE));
    end

    // Largest coin not exceeding the balance; zero means only a sub-5 residue is left.
    always_comb begin
        chg_coin = '0;
        chg_val  = '0;
        if (balance_q >= BAL_W'(Coin25Val)) begin
            chg_coin = Coin25Bit;
            chg_val  = BAL_W'(Coin25Val);
        end else if (balance_q >= BAL_W'(Coin10Val)) begin
            chg_coin = Coin10Bit;
            chg_val  = BAL_W'(Coin10Val);
        end else if (balance_q >= BAL_W'(Coin5Val)) begin
            chg_coin = Coin5Bit;
            chg_val  = BAL_W'(Coin5Val);
        end
    end

    // Controller FSM with credit register and registered status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            balance_q     <= '0;
            cost_q        <= '0;
            gap_q         <= '0;
            vend_q        <= '0;
            change_coin_q <= '0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            vend_q        <= '0;
            change_coin_q <= '0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (refund) begin
                        if (balance_q != '0) begin
                            state_q <= StChange;
                            gap_q   <= GapReload;
                        end
                    end else if (buy) begin
                        if (!prod_ok || balance_q < prod_cost) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= StVend;
                            vend_q  <= product;
                            cost_q  <= prod_cost;
                        end
                    end
                    // A coin alongside buy/refund is bounced so credit never races a debit.
                    if (coin != '0) begin
                        if (!coin_ok || !coin_fits || buy || refund) begin
                            coin_reject_q <= 1'b1;
                        end else begin
                            balance_q <= balance_q + coin_val;
                        end
                    end
                end
                StVend: begin
                    coin_reject_q <= (coin != '0);
                    if (balance_q > cost_q) begin
                        balance_q <= balance_q - cost_q;
                        state_q   <= StChange;
                        gap_q     <= GapReload;
                    end else begin
                        balance_q <= '0;
                        state_q   <= StIdle;
                    end
                end
                StChange: begin
                    coin_reject_q <= (coin != '0);
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GapW'(1);
                    end else begin
                        gap_q         <= GapReload;
                        change_coin_q <= chg_coin;
                        if (chg_coin != '0 && balance_q > chg_val) begin
                            balance_q <= balance_q - chg_val;
                        end else begin
                            balance_q <= '0;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign balance     = balance_q;
    assign vend        = vend_q;
    assign change_coin = change_coin_q;
    assign coin_reject = coin_reject_q;
    assign err         = err_q;
    assign busy        = (state_q != StIdle);

    vend_ctrl_mux_scan #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BAL_W       (BAL_W)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .balance (balance_q),
        .cost    (prod_cost),
        .AN      (AN),
        .CA      (CA)
    );

endmodule
